// File: rtl/rps_pkg.sv
// Shared move codes, result encodings, FSM states and mode-dependent sizes for the RPS engine.
// RPSLS_EN selects the five-move rock-paper-scissors-lizard-spock variant.
package rps_pkg;

    localparam logic [2:0] MV_ROCK       = 3'd0;
    localparam logic [2:0] MV_PAPER      = 3'd1;
    localparam logic [2:0] MV_SCISSORS   = 3'd2;

    localparam logic [2:0] MV5_ROCK      = 3'd0;
    localparam logic [2:0] MV5_SPOCK     = 3'd1;
    localparam logic [2:0] MV5_PAPER     = 3'd2;
    localparam logic [2:0] MV5_LIZARD    = 3'd3;
    localparam logic [2:0] MV5_SCISSORS  = 3'd4;

    localparam logic [2:0] RES_NONE      = 3'b000;
    localparam logic [2:0] RES_PERSON    = 3'b001;
    localparam logic [2:0] RES_CPU       = 3'b010;
    localparam logic [2:0] RES_TIE       = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_JUDGE,
        ST_SHOW,
        ST_MATCH_OVER
    } state_t;

`ifdef RPSLS_EN
    localparam int N_MOVES = 5;
`else
    localparam int N_MOVES = 3;
`endif
    localparam int MOVE_W = 3;

    // d = (p - c) mod N; the lower half of the nonzero residues beats the opponent.
    function automatic logic [2:0] judge(input logic [2:0] p, input logic [2:0] c);
        logic [3:0] d;
        d = {1'b0, p} + 4'(N_MOVES) - {1'b0, c};
        if (d >= 4'(N_MOVES))
            d = d - 4'(N_MOVES);
        if (d == 4'd0)
            return RES_TIE;
        else if (d <= 4'((N_MOVES - 1) / 2))
            return RES_PERSON;
        else
            return RES_CPU;
    endfunction

endpackage

// File: rtl/rps_match_engine_if.sv
// Button input and LED/score outputs of the RPS match engine bundled as one interface.
interface rps_match_engine_if #(
    parameter int SCORE_W = 3
);
    logic [4:0]         BTN;
    logic [2:0]         result;
    logic [2:0]         person_move;
    logic [2:0]         cpu_move;
    logic [SCORE_W-1:0] person_score;
    logic [SCORE_W-1:0] cpu_score;
    logic               round_done;
    logic               match_over;
    logic               match_winner;

    modport master (
        output BTN,
        input  result, person_move, cpu_move, person_score, cpu_score,
        input  round_done, match_over, match_winner
    );

    modport slave (
        input  BTN,
        output result, person_move, cpu_move, person_score, cpu_score,
        output round_done, match_over, match_winner
    );
endinterface

// File: rtl/rps_debounce.sv
// One button: 2-FF synchroniser, then a level that flips only after DEBOUNCE_CYCLES
// consecutive samples disagreeing with it.
module rps_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
endmodule

// File: rtl/rps_match_engine.sv
// Best-of-N rock-paper-scissors engine: debounced buttons vs a free-running move counter.
// RPSLS_EN switches from classic (N=3) to rock-paper-scissors-lizard-spock (N=5).
module rps_match_engine
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 12000000,
    parameter int WIN_TARGET      = 3,
    parameter int SCORE_W         = 3
) (
    input  logic              CLK,
    input  logic              RST,
    rps_match_engine_if.slave bus
);
    localparam int                 HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [4:0]         MOVE_MASK = 5'((1 << N_MOVES) - 1);
    localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= TARGET) ? s : s + 1'b1;
    endfunction

    logic [4:0]        w_level;
    logic [4:0]        r_level_d;
    logic [4:0]        w_rise;
    logic              w_press;
    logic [2:0]        w_press_code;
    logic [2:0]        w_verdict;
    logic              w_hold_done;
    logic              w_at_target;
    logic [MOVE_W-1:0] r_mv_cnt;
    logic [HOLD_W-1:0] r_hold;
    state_t            r_state;
    state_t            w_state_nxt;

    logic [2:0]         r_result;
    logic [2:0]         r_pmove;
    logic [2:0]         r_cmove;
    logic [SCORE_W-1:0] r_pscore;
    logic [SCORE_W-1:0] r_cscore;
    logic               r_round_done;
    logic               r_match_over;
    logic               r_match_winner;

    for (genvar gi = 0; gi < 5; gi++) begin : g_deb
        rps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_btn   (bus.BTN[gi]),
            .o_level (w_level[gi])
        );
    end

    assign w_rise  = w_level & ~r_level_d & MOVE_MASK;
    assign w_press = |w_rise;

    // Lowest index wins when several buttons edge in the same cycle.
    always_comb begin
        w_press_code = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (w_rise[i])
                w_press_code = 3'(i);
    end

    assign w_verdict   = judge(w_press_code, r_mv_cnt);
    assign w_hold_done = (r_hold == HOLD_W'(HOLD_CYCLES - 1));
    assign w_at_target = (r_pscore == TARGET) || (r_cscore == TARGET);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_mv_cnt <= '0;
        else if (r_mv_cnt == MOVE_W'(N_MOVES - 1))
            r_mv_cnt <= '0;
        else
            r_mv_cnt <= r_mv_cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:       if ((w_level & MOVE_MASK) == 5'd0) w_state_nxt = ST_ARMED;
            ST_ARMED:      if (w_press) w_state_nxt = ST_JUDGE;
            ST_JUDGE:      w_state_nxt = ST_SHOW;
            ST_SHOW:       if (w_hold_done) w_state_nxt = w_at_target ? ST_MATCH_OVER : ST_IDLE;
            ST_MATCH_OVER: if (w_press) w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    // Round outputs are registered on the press edge so they are visible during JUDGE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_level_d      <= '0;
            r_hold         <= '0;
            r_result       <= RES_NONE;
            r_pmove        <= '0;
            r_cmove        <= '0;
            r_pscore       <= '0;
            r_cscore       <= '0;
            r_round_done   <= 1'b0;
            r_match_over   <= 1'b0;
            r_match_winner <= 1'b0;
        end else begin
            r_level_d    <= w_level;
            r_round_done <= 1'b0;
            case (r_state)
                ST_ARMED: begin
                    if (w_press) begin
                        r_pmove      <= w_press_code;
                        r_cmove      <= r_mv_cnt;
                        r_result     <= w_verdict;
                        r_round_done <= 1'b1;
                        if (w_verdict == RES_PERSON) r_pscore <= sat_inc(r_pscore);
                        if (w_verdict == RES_CPU)    r_cscore <= sat_inc(r_cscore);
                    end
                end
                ST_JUDGE: r_hold <= '0;
                ST_SHOW: begin
                    if (w_hold_done) begin
                        if (w_at_target) begin
                            r_match_over   <= 1'b1;
                            r_match_winner <= (r_cscore == TARGET);
                            r_result       <= (r_cscore == TARGET) ? RES_CPU : RES_PERSON;
                        end else begin
                            r_result <= RES_NONE;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_MATCH_OVER: begin
                    if (w_press) begin
                        r_pscore       <= '0;
                        r_cscore       <= '0;
                        r_result       <= RES_NONE;
                        r_match_over   <= 1'b0;
                        r_match_winner <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result       = r_result;
    assign bus.person_move  = r_pmove;
    assign bus.cpu_move     = r_cmove;
    assign bus.person_score = r_pscore;
    assign bus.cpu_score    = r_cscore;
    assign bus.round_done   = r_round_done;
    assign bus.match_over   = r_match_over;
    assign bus.match_winner = r_match_winner;
endmodule
